ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single-ported 4K x 32b CPU RAM between the instruction-fetch requester (if_*) and the
//  load/store requester (d_*, lw/sw). Fixed priority to data with a starvation guard for fetch.
//  At most one RAM access per cycle. Read data is routed back to the requester that issued the read.
//  Sits between fetch/decode-execute logic and the RAM macro (synchronous read, 1-cycle latency).
// PARAMETERS
//  ADDR_W      12  RAM word-address width (4096 words)
//  DATA_W      32  RAM word width
//  STARVE_MAX  3   max consecutive data grants while fetch is waiting; range 1..15
// PORTS
//  clk        in   1       system clock, all state on posedge
//  reset      in   1       synchronous, active-high
//  if_req     in   1       fetch read request; held until if_gnt
//  if_addr    in   ADDR_W  fetch word address
//  if_gnt     out  1       fetch request accepted this cycle
//  if_rvalid  out  1       if_rdata valid (cycle after if_gnt)
//  if_rdata   out  DATA_W  fetched instruction word
//  d_req      in   1       data request; held until d_gnt
//  d_we       in   1       1 = store (sw), 0 = load (lw)
//  d_addr     in   ADDR_W  data word address
//  d_wdata    in   DATA_W  store data
//  d_gnt      out  1       data request accepted this cycle
//  d_rvalid   out  1       d_rdata valid (cycle after a load grant; never for stores)
//  d_rdata    out  DATA_W  load data
//  ram_en     out  1       RAM access this cycle
//  ram_we     out  1       RAM write enable
//  ram_addr   out  ADDR_W  RAM address
//  ram_wdata  out  DATA_W  RAM write data
//  ram_rdata  in   DATA_W  RAM read data, valid cycle after ram_en & !ram_we
// BEHAVIOUR
//  - Grant is combinational in the request cycle; if_gnt and d_gnt are never both 1.
//  - Winner: only one req -> that one. Both -> data, unless starve_cnt == STARVE_MAX -> fetch.
//  - starve_cnt (registered, 4b): +1 on a cycle where d_gnt=1 and if_req=1;
//    cleared on if_gnt or when if_req=0; never exceeds STARVE_MAX.
//  - ram_en = if_gnt | d_gnt; ram_we = d_gnt & d_we; ram_addr/ram_wdata muxed from winner.
//    ram_addr/ram_wdata = 0 when ram_en=0.
//  - Read tag register rd_owner[1:0] = {d_gnt&!d_we, if_gnt}, captured each cycle.
//    Next cycle: if_rvalid = rd_owner[0], d_rvalid = rd_owner[1].
//  - if_rdata/d_rdata = ram_rdata when own rvalid=1, else 0.
//  - Latency: read data 1 cycle after grant; back-to-back grants every cycle, no bubbles.
//    A write takes one cycle, produces no response.
//  - Reset: if_gnt, d_gnt, ram_en, ram_we forced 0 while reset=1; starve_cnt=0, rd_owner=0.
//    So if_rvalid, d_rvalid, rdata = 0 in the cycle after reset.
//    A read granted the cycle before reset is dropped: rvalid stays 0.
//  - Requests present during reset are not granted; arbitration resumes the first cycle reset=0.
//  - Requester changing addr/we/wdata while req=1 and not granted: the value at grant is used.
// TESTING
//  1. RAM[5]=32'hDEADBEEF; if_req=1, if_addr=5 -> if_gnt same cycle;
//     next cycle if_rvalid=1, if_rdata=DEADBEEF, d_rvalid=0.
//  2. d_req,d_we=1,d_addr=12'hFFF,d_wdata=32'h12345678, then load 12'hFFF
//     -> ram_we 1 then 0; d_rvalid once, d_rdata=12345678.
//  3. STARVE_MAX=3, both req held 8 cycles -> grants D,D,D,F,D,D,D,F; rvalid follows owner 1 cycle later.
//  4. Both req 2 cycles (D,D), if_req low 1 cycle, both req again
//     -> starve_cnt cleared; next 3 grants D, then F.
//  5. Load granted cycle N, reset=1 in cycle N+1 -> d_rvalid=0 in N+1, N+2; all grants 0 while reset.
//  6. Alternate F load addr 1 / D load addr 2 every cycle -> each rvalid/rdata pair matches issuer;
//     never both rvalids high.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-ported, synchronous-read RAM between the instruction
//   fetch requester (if_*) and the load/store requester (d_*). Data has fixed
//   priority. A starvation counter gives fetch the port after STARVE_MAX
//   consecutive data grants that fetch had to wait through. At most one RAM
//   access is made per cycle. Read data comes back one cycle after the grant
//   and is steered to whichever requester issued the read.
//
// Ports
//   clk, reset                     clock and synchronous active-high reset
//   if_req/if_addr                 fetch read request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata      fetch grant and read response
//   d_req/d_we/d_addr/d_wdata      load/store request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata         data grant and load response
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata   RAM macro interface
module ram_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  // Number of consecutive data grants that fetch has waited through.
  logic [3:0] starve_cnt;
  // {data load issued, fetch issued} in the previous cycle.
  logic [1:0] rd_owner;
  logic       fetch_starved;

  assign fetch_starved = (starve_cnt == 4'(STARVE_MAX));

  // Grant is combinational in the request cycle; nothing is granted in reset.
  always_comb begin
    // NOTE: every output of a combinational block gets a default up front so
    // no path leaves it unassigned, which would otherwise infer a latch.
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!reset) begin
      if (d_req && !(if_req && fetch_starved)) d_gnt  = 1'b1;
      else if (if_req)                         if_gnt = 1'b1;
    end
  end

  // RAM port is driven from the winner; address and data idle at zero.
  always_comb begin
    ram_en    = if_gnt | d_gnt;
    ram_we    = d_gnt & d_we;
    ram_addr  = '0;
    ram_wdata = '0;
    if (d_gnt) begin
      ram_addr  = d_addr;
      ram_wdata = d_wdata;
    end else if (if_gnt) begin
      ram_addr  = if_addr;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 4'd0;
      rd_owner   <= 2'b00;
    end else begin
      if (if_gnt || !if_req)
        starve_cnt <= 4'd0;
      else if (d_gnt && !fetch_starved)
        starve_cnt <= starve_cnt + 4'd1;
      rd_owner <= {d_gnt & ~d_we, if_gnt};
    end
  end

  // The reset term drops a read that was granted in the cycle just before
  // reset: its tag is still in rd_owner during the first reset cycle.
  assign if_rvalid = rd_owner[0] & ~reset;
  assign d_rvalid  = rd_owner[1] & ~reset;
  assign if_rdata  = if_rvalid ? ram_rdata : '0;
  assign d_rdata   = d_rvalid  ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
//   Directed bench for ram_port_arbiter with a behavioural synchronous-read
//   RAM attached. Inputs change 1 time unit after posedge; outputs are
//   sampled 3 units after posedge, before the next edge.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [11:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [11:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        ram_en, ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;

  logic [31:0] mem [0:4095];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Synchronous-read RAM, one cycle latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  ram_port_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Advance to just after the next posedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic [11:0] ia, input logic dr,
                       input logic dw, input logic [11:0] da, input logic [31:0] wd);
    if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = wd;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      reset = 1'b1;
      drive(1'b1, 12'd5, 1'b1, 1'b0, 12'd7, 32'd0);
      #2;
      total++;
      if ({if_gnt, d_gnt, ram_en, ram_we} !== 4'b0000) begin
        bad++;
        $display("FAIL rst_grants[%0d] got=%b want=0000", i, {if_gnt, d_gnt, ram_en, ram_we});
      end
      total++;
      if ({if_rvalid, d_rvalid, if_rdata != 0, d_rdata != 0} !== 4'b0000) begin
        bad++;
        $display("FAIL rst_rvalid[%0d] got=%b want=0000", i,
                 {if_rvalid, d_rvalid, if_rdata != 0, d_rdata != 0});
      end
    end
    // First cycle out of reset: requests still held, data wins immediately.
    next_cycle();
    reset = 1'b0;
    #2;
    total++;
    if ({if_gnt, d_gnt} !== 2'b01) begin
      bad++;
      $display("FAIL rst_resume got=%b want=01", {if_gnt, d_gnt});
    end
    next_cycle();
    drive(1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 32'd0);
    #2;
    total++;
    if ({if_rvalid, d_rvalid} !== 2'b01) begin
      bad++;
      $display("FAIL rst_resume_rvalid got=%b want=01", {if_rvalid, d_rvalid});
    end
  endtask

  task automatic test_fetch_read();
    next_cycle();
    drive(1'b1, 12'd5, 1'b0, 1'b0, 12'd0, 32'd0);
    #2;
    total++;
    if ({if_gnt, d_gnt, ram_en, ram_we} !== 4'b1010 || ram_addr !== 12'd5) begin
      bad++;
      $display("FAIL f_grant got=%b addr=%h want=1010 addr=005",
               {if_gnt, d_gnt, ram_en, ram_we}, ram_addr);
    end
    next_cycle();
    drive(1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 32'd0);
    #2;
    total++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL f_rdata got=%b/%h want=1/deadbeef", if_rvalid, if_rdata);
    end
    total++;
    if (d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin
      bad++;
      $display("FAIL f_d_quiet got=%b/%h want=0/0", d_rvalid, d_rdata);
    end
    total++;
    if (ram_en !== 1'b0 || ram_addr !== 12'h0 || ram_wdata !== 32'h0) begin
      bad++;
      $display("FAIL idle_bus got en=%b addr=%h wdata=%h want 0/0/0", ram_en, ram_addr, ram_wdata);
    end
  endtask

  task automatic test_store_load();
    next_cycle();
    drive(1'b0, 12'd0, 1'b1, 1'b1, 12'hFFF, 32'h12345678);
    #2;
    total++;
    if ({d_gnt, ram_en, ram_we} !== 3'b111 || ram_addr !== 12'hFFF || ram_wdata !== 32'h12345678) begin
      bad++;
      $display("FAIL sw_bus got=%b addr=%h wdata=%h want=111 fff 12345678",
               {d_gnt, ram_en, ram_we}, ram_addr, ram_wdata);
    end
    next_cycle();
    drive(1'b0, 12'd0, 1'b1, 1'b0, 12'hFFF, 32'h0);
    #2;
    total++;
    if ({d_gnt, ram_en, ram_we, d_rvalid} !== 4'b1100 || ram_addr !== 12'hFFF) begin
      bad++;
      $display("FAIL lw_bus got=%b addr=%h want=1100 fff", {d_gnt, ram_en, ram_we, d_rvalid}, ram_addr);
    end
    next_cycle();
    drive(1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 32'd0);
    #2;
    total++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h12345678 || if_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL lw_rdata got=%b/%h if_rvalid=%b want=1/12345678 0", d_rvalid, d_rdata, if_rvalid);
    end
    next_cycle();
    #2;
    total++;
    if (d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin
      bad++;
      $display("FAIL lw_once got=%b/%h want=0/0", d_rvalid, d_rdata);
    end
  endtask

  task automatic test_starvation();
    logic [7:0] exp_d = 8'b0111_0111;  // bit i = data wins in cycle i
    logic       prev_d = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      next_cycle();
      if (i < 8) drive(1'b1, 12'd5, 1'b1, 1'b0, 12'hFFF, 32'd0);
      else       drive(1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 32'd0);
      #2;
      if (i < 8) begin
        total++;
        if ({if_gnt, d_gnt} !== {~exp_d[i], exp_d[i]}) begin
          bad++;
          $display("FAIL starve_gnt[%0d] got if=%b d=%b want if=%b d=%b",
                   i, if_gnt, d_gnt, ~exp_d[i], exp_d[i]);
        end
      end
      if (i > 0) begin
        prev_d = exp_d[i-1];
        total++;
        if ({if_rvalid, d_rvalid} !== {~prev_d, prev_d} ||
            (prev_d ? d_rdata : if_rdata) !== (prev_d ? 32'h12345678 : 32'hDEADBEEF)) begin
          bad++;
          $display("FAIL starve_rsp[%0d] got rv=%b%b if=%h d=%h want d_owner=%b",
                   i, if_rvalid, d_rvalid, if_rdata, d_rdata, prev_d);
        end
      end
    end
  endtask

  task automatic test_starve_clear();
    logic [6:0] ireq  = 7'b111_1011;  // bit i = fetch requesting in cycle i
    logic [6:0] exp_d = 7'b011_1111;
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      drive(ireq[i], 12'd5, 1'b1, 1'b0, 12'hFFF, 32'd0);
      #2;
      total++;
      if ({if_gnt, d_gnt} !== {ireq[i] & ~exp_d[i], exp_d[i]}) begin
        bad++;
        $display("FAIL clear_gnt[%0d] got if=%b d=%b want if=%b d=%b",
                 i, if_gnt, d_gnt, ireq[i] & ~exp_d[i], exp_d[i]);
      end
    end
    next_cycle();
    drive(1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 32'd0);
  endtask

  task automatic test_reset_drop();
    next_cycle();
    drive(1'b0, 12'd0, 1'b1, 1'b0, 12'hFFF, 32'd0);
    #2;
    total++;
    if (d_gnt !== 1'b1) begin
      bad++;
      $display("FAIL drop_gnt got=%b want=1", d_gnt);
    end
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      reset = 1'b1;
      drive(1'b1, 12'd5, 1'b1, 1'b0, 12'hFFF, 32'd0);
      #2;
      total++;
      if ({d_rvalid, if_rvalid, if_gnt, d_gnt, ram_en} !== 5'b00000 || d_rdata !== 32'h0) begin
        bad++;
        $display("FAIL drop_rst[%0d] got=%b d_rdata=%h want=00000 0",
                 i, {d_rvalid, if_rvalid, if_gnt, d_gnt, ram_en}, d_rdata);
      end
    end
    next_cycle();
    reset = 1'b0;
    drive(1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 32'd0);
    #2;
    total++;
    if ({d_rvalid, if_rvalid} !== 2'b00) begin
      bad++;
      $display("FAIL drop_after got=%b want=00", {d_rvalid, if_rvalid});
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i <= 8; i++) begin
      next_cycle();
      if (i == 8)     drive(1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 32'd0);
      else if (i % 2) drive(1'b0, 12'd0, 1'b1, 1'b0, 12'd2, 32'd0);
      else            drive(1'b1, 12'd1, 1'b0, 1'b0, 12'd0, 32'd0);
      #2;
      if (i < 8) begin
        total++;
        if ({if_gnt, d_gnt} !== ((i % 2) ? 2'b01 : 2'b10)) begin
          bad++;
          $display("FAIL b2b_gnt[%0d] got=%b%b", i, if_gnt, d_gnt);
        end
      end
      if (i > 0) begin
        total++;
        if ((i % 2) ? (if_rvalid !== 1'b1 || if_rdata !== 32'hAAAA0001 || d_rvalid !== 1'b0 || d_rdata !== 32'h0)
                    : (d_rvalid !== 1'b1 || d_rdata !== 32'hBBBB0002 || if_rvalid !== 1'b0 || if_rdata !== 32'h0)) begin
          bad++;
          $display("FAIL b2b_rsp[%0d] got if=%b/%h d=%b/%h", i, if_rvalid, if_rdata, d_rvalid, d_rdata);
        end
      end
    end
  endtask

  initial begin
    mem[5] = 32'hDEADBEEF;
    mem[1] = 32'hAAAA0001;
    mem[2] = 32'hBBBB0002;
    mem[12'h7] = 32'h0;
    test_reset();
    test_fetch_read();
    test_store_load();
    test_starvation();
    test_starve_clear();
    test_reset_drop();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
